// File: rtl/flac_pkg.sv
// Shared FLAC encoder types: FSM state encoding, fixed bus widths, zigzag helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package flac_pkg;

  localparam int WORD_W       = 16;
  localparam int ADDR_W       = 16;
  localparam int RICE_PARAM_W = 4;
  // fill counts 0..16 bits, so one bit wider than log2(WORD_W)
  localparam int FILL_W       = 5;

  typedef enum logic [2:0] {
    IDLE,
    UNARY,
    STOP,
    REM,
    FLUSH,
    DONE
  } state_t;

  // Signed-to-unsigned fold: 0->0, -1->1, 1->2, -32768->65535.
  function automatic logic [WORD_W-1:0] zigzag(input logic [WORD_W-1:0] r);
    return {r[WORD_W-2:0], 1'b0} ^ {WORD_W{r[WORD_W-1]}};
  endfunction

endpackage

// File: rtl/bit_packer.sv
// Packs a serial bit stream MSB-first into 16-bit RAM words; zero-pads on flush.
// Latency: write strobe one cycle after the 16th bit (or after the flush request).
// Backpressure: none; caller only presents bits/flush on enabled cycles.
module bit_packer
  import flac_pkg::*;
(
  input  logic              iClock,
  input  logic              iReset,
  input  logic [ADDR_W-1:0] iStartAddr,
  input  logic              bit_vld,
  input  logic              bit_dat,
  input  logic              flush_vld,
  output logic [WORD_W-1:0] oWriteData,
  output logic [ADDR_W-1:0] oWriteAddr,
  output logic              oWriteEnable
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WORD_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WORD_W - 1);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  logic [WORD_W-1:0] sr;
  logic [FILL_W-1:0] fill;

  // Shift incoming bits, emit full or flushed words, advance address after each write.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      sr           <= '0;
      fill         <= '0;
      oWriteData   <= '0;
      oWriteAddr   <= iStartAddr;
      oWriteEnable <= 1'b0;
    end else begin
      // Strobe is a single-cycle pulse; the address step must complete
      // even if the stream is stalled in the cycle after a write.
      oWriteEnable <= 1'b0;
      if (oWriteEnable) begin
        oWriteAddr <= oWriteAddr + ADDR_ONE;
      end
      if (flush_vld) begin
        if (fill != '0) begin
          // Only the low 'fill' bits are live; shifting left discards stale history.
          oWriteData   <= sr << (FILL_FULL - fill);
          oWriteEnable <= 1'b1;
        end
        sr   <= '0;
        fill <= '0;
      end else if (bit_vld) begin
        sr <= {sr[WORD_W-2:0], bit_dat};
        if (fill == FILL_LAST) begin
          oWriteData   <= {sr[WORD_W-2:0], bit_dat};
          oWriteEnable <= 1'b1;
          fill         <= '0;
        end else begin
          fill <= fill + FILL_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/rice_residual_encoder.sv
// Rice-codes signed 16-bit residuals (q zeros, '1', k remainder bits) into packed RAM words.
// Latency: first code bit the cycle after accept; one bit per enabled cycle; q+k+2 cycles per residual.
// Backpressure: oReady only in IDLE; iEnable low freezes all state and emission.
module rice_residual_encoder
  import flac_pkg::*;
(
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic                    iEnable,
  input  logic [ADDR_W-1:0]       iStartAddr,
  input  logic [RICE_PARAM_W-1:0] iRiceParam,
  input  logic [WORD_W-1:0]       iResidual,
  input  logic                    iValid,
  output logic                    oReady,
  input  logic                    iFlush,
  output logic [WORD_W-1:0]       oWriteData,
  output logic [ADDR_W-1:0]       oWriteAddr,
  output logic                    oWriteEnable,
  output logic                    oDone
);

  localparam logic [WORD_W-1:0]       Q_ONE = WORD_W'(1);
  localparam logic [RICE_PARAM_W-1:0] K_ONE = RICE_PARAM_W'(1);

  state_t                  state_q, state_d;
  logic [WORD_W-1:0]       u_q, u_d;
  logic [WORD_W-1:0]       q_q, q_d;
  logic [RICE_PARAM_W-1:0] k_q, k_d;
  logic [RICE_PARAM_W-1:0] idx_q, idx_d;

  logic [WORD_W-1:0] u_in;
  logic [WORD_W-1:0] q_in;
  logic              run;
  logic              bit_vld;
  logic              bit_dat;
  logic              flush_vld;

  // An enabled, non-reset cycle is the only time anything may be emitted.
  assign run  = iEnable & ~iReset;
  assign u_in = zigzag(iResidual);
  assign q_in = u_in >> iRiceParam;

  // State and latched code parameters; frozen while iEnable is low.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= IDLE;
      u_q     <= '0;
      q_q     <= '0;
      k_q     <= '0;
      idx_q   <= '0;
    end else if (iEnable) begin
      state_q <= state_d;
      u_q     <= u_d;
      q_q     <= q_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state decode and per-cycle code bit selection.
  always_comb begin
    state_d   = state_q;
    u_d       = u_q;
    q_d       = q_q;
    k_d       = k_q;
    idx_d     = idx_q;
    oReady    = 1'b0;
    oDone     = 1'b0;
    bit_vld   = 1'b0;
    bit_dat   = 1'b0;
    flush_vld = 1'b0;
    case (state_q)
      IDLE: begin
        oReady = ~iReset;
        // Flush wins over a simultaneous residual; the residual stays pending.
        if (iFlush) begin
          flush_vld = run;
          state_d   = FLUSH;
        end else if (iValid) begin
          u_d     = u_in;
          k_d     = iRiceParam;
          q_d     = q_in;
          state_d = (q_in == '0) ? STOP : UNARY;
        end
      end
      UNARY: begin
        bit_vld = run;
        bit_dat = 1'b0;
        q_d     = q_q - Q_ONE;
        if (q_q == Q_ONE) begin
          state_d = STOP;
        end
      end
      STOP: begin
        bit_vld = run;
        bit_dat = 1'b1;
        idx_d   = k_q - K_ONE;
        state_d = (k_q != '0) ? REM : IDLE;
      end
      REM: begin
        bit_vld = run;
        bit_dat = u_q[idx_q];
        idx_d   = idx_q - K_ONE;
        if (idx_q == '0) begin
          state_d = IDLE;
        end
      end
      // Packer's flush write is visible during this state.
      FLUSH: begin
        state_d = DONE;
      end
      DONE: begin
        oDone   = run;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  bit_packer u_bit_packer (
    .iClock       (iClock),
    .iReset       (iReset),
    .iStartAddr   (iStartAddr),
    .bit_vld      (bit_vld),
    .bit_dat      (bit_dat),
    .flush_vld    (flush_vld),
    .oWriteData   (oWriteData),
    .oWriteAddr   (oWriteAddr),
    .oWriteEnable (oWriteEnable)
  );

endmodule

// File: doc/rice_residual_encoder.md
# rice_residual_encoder

Encodes a stream of signed 16-bit FLAC residuals into a Rice-coded bitstream and packs it MSB-first into 16-bit words written to block RAM. It is the transmit-side counterpart of the residual decoder and sits between the LPC/fixed-predictor residual generator and the frame RAM. Output is one bit per enabled cycle, which matches the decoder's consumption rate. Partition headers and escape codes are written by the frame writer, not by this block.

## Interface
- Parameters: none; all widths are fixed (word 16 bits, address 16 bits, Rice parameter 4 bits).
- iClock  in  1  clock.
- iReset  in  1  synchronous, active-high reset.
- iEnable  in  1  while low, all state is frozen; no bit is emitted and no input is accepted.
- iStartAddr  in  16  first RAM write address; sampled while iReset is high.
- iRiceParam  in  4  Rice parameter k (0..15); sampled together with the residual.
- iResidual  in  16  signed residual.
- iValid  in  1  iResidual/iRiceParam are valid.
- oReady  out  1  high in IDLE; a transfer occurs when iValid & oReady & iEnable.
- iFlush  in  1  in IDLE: zero-pad and write the partial word, then pulse oDone.
- oWriteData  out  16  RAM write data.
- oWriteAddr  out  16  RAM write address.
- oWriteEnable  out  1  one-cycle write strobe.
- oDone  out  1  one-cycle pulse when a flush completes.

## Operation
- Zigzag map: u = (r << 1) ^ (r >>> 15), 16-bit unsigned (0→0, −1→1, 1→2, −32768→65535). Quotient q = u >> k (16-bit); remainder = the low k bits of u.
- Code per residual: q zeros, then one '1', then the k remainder bits MSB first.
- FSM:
  - IDLE: oReady=1. iFlush has priority over iValid. On accept, latch u and k and go to UNARY, or to STOP if q=0.
  - UNARY: emit '0' and decrement q. When q reaches 1, go to STOP.
  - STOP: emit '1'. Go to REM if k>0, otherwise IDLE.
  - REM: emit bit k−1 down to bit 0. After bit 0, go to IDLE.
  - FLUSH: if fill>0, write the shift register left-aligned and zero-padded (sr << (16−fill)). Go to DONE.
  - DONE: oDone=1, fill=0, go to IDLE.
- Packer:
  - Each emitted bit shifts into sr[0] and increments fill.
  - When fill reaches 16, write {sr[14:0], bit}, set fill to 0, and post-increment the address.
- oWriteAddr shows the address of the word being written. It advances the cycle after each write.
- A flush with fill=0 performs no write; oDone still pulses.

## Timing
- Reset values:
  - oWriteEnable=0, oWriteData=0, oDone=0.
  - oReady=0 while iReset is high.
  - oWriteAddr=iStartAddr.
  - fill=0, state IDLE.
  - oReady=1 the first cycle after reset is released.
- Accept in cycle N; first code bit in N+1. A residual occupies q+k+2 enabled cycles from accept to the next oReady.
- oWriteEnable is registered. It is high exactly the cycle after the 16th bit is shifted, and it clears on the next edge even if iEnable is low.
- Flush: accept in N; write (if any) in N+1; oDone in N+2.
- iEnable low: no state changes and no new strobes. The stream is unchanged, only delayed.
- iReset mid-residual or mid-flush: partial bits are discarded, no write occurs, and the address reloads.

## Structure
- Shared package flac_pkg holds: the state enum (IDLE, UNARY, STOP, REM, FLUSH, DONE), WORD_W=16, ADDR_W=16, RICE_PARAM_W=4.
- Sub-module bit_packer owns sr, fill, address and the write strobe. Its inputs are bit-valid, bit, and flush. The top level contains the FSM and the zigzag/quotient logic.

## Test plan
- Reset with iStartAddr=0x0100. Send r=3, k=2 (u=6, bits 0110), then flush → one write 0x6000 @0x0100; oDone two cycles after the flush is accepted.
- Send eight r=−1, k=0 back-to-back → each residual occupies 3 cycles; a single write 0x5555 @iStartAddr; no flush needed.
- Send r=−32768, k=15, then flush → 0x7FFF @A, then 0x8000 @A+1.
- Flush with fill=0 → no oWriteEnable; oDone exactly 2 cycles after the flush is accepted; oWriteAddr unchanged.
- Send r=20, k=0 (u=40: 40 zeros then '1') with iEnable held low for 5 cycles mid-UNARY → output words identical to the unstalled run, strobes 5 cycles later.
- Assert iReset during UNARY → no write, oWriteAddr=new iStartAddr, oReady=1 the cycle after release; the next residual encodes from bit 0 of a fresh word.
